spi_adc_responder: RTL
======================

Name: spi_adc_responder

Overview:
- Behavioural SPI responder emulating a 2-channel, 12-bit MCP3202-class ADC.
- It is the target end of the SPI link driven by the ADC controller (SPI_SCK/SPI_AD/SPI_DIN/SPI_DOUT), and is used in system benches and in FPGA self-test builds.
- Channel values are supplied on ports. Frames arriving on the oversampled SPI inputs are decoded, and MISO is driven back exactly as the real converter would drive it.

Parameters:
- SYNC_STAGES, 2: synchroniser depth on spi_sck, spi_cs_n and spi_mosi (legal values 2–3).
- IDLE_MISO, 1'b0: spi_miso level whenever spi_miso_oe=0.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- spi_sck  in  1  SPI clock from the initiator; asynchronous to clk.
- spi_cs_n  in  1  chip select, active low.
- spi_mosi  in  1  initiator data (DIN).
- spi_miso  out  1  responder data (DOUT).
- spi_miso_oe  out  1  output enable; 1 while a conversion is being shifted out.
- ch0_value  in  12  CH0 analogue value.
- ch1_value  in  12  CH1 analogue value.
- conv_done  out  1  one-clk pulse after the final data bit is driven.
- last_ch  out  1  ODD/SIGN bit of the last completed frame.
- last_sgl  out  1  SGL/DIFF bit of the last completed frame.
- frame_abort  out  1  one-clk pulse when CS_n deasserts mid-frame.

Behaviour:
- Reset values: spi_miso=IDLE_MISO, spi_miso_oe=0, conv_done=0, frame_abort=0, last_ch=0, last_sgl=0, state=IDLE, all synchronisers cleared to 0 except cs_n, which is cleared to 1.
- Input sampling:
  - All three SPI inputs pass through SYNC_STAGES flops.
  - Edges are detected against the previous synchronised sample.
  - Response latency from a synchronised SCK falling edge to the spi_miso update is exactly 1 clk.
  - Required SCK high/low time is at least SYNC_STAGES+2 clk periods; behaviour is unspecified below that.
- State machine:
  - IDLE: spi_miso_oe=0. A synchronised cs_n falling edge moves to START.
  - START: on each SCK rising edge, sample mosi. 0 stays in START (leading zeros are allowed); 1 moves to CFG with cfg_cnt=0.
  - CFG: three SCK rising edges capture SGL, ODD and MSBF in that order. On the MSBF edge, latch the 12-bit sample (see arithmetic) and move to NULL.
  - NULL: on the next SCK falling edge, drive spi_miso=0 and spi_miso_oe=1, then move to MSB.
  - MSB: on each SCK falling edge, drive D11 down to D0, counting with bit_cnt 11→0.
    - After D0 is driven, pulse conv_done and update last_ch/last_sgl.
    - If MSBF=1, move to HOLD. If MSBF=0, move to LSB.
  - LSB: on each SCK falling edge, drive D1 up to D11 (D0 is not repeated), then move to HOLD.
  - HOLD: spi_miso=0 with oe=1 on every further falling edge, until CS_n rises.
  - Any state except IDLE: a synchronised cs_n rising edge returns to IDLE with spi_miso_oe=0 and spi_miso=IDLE_MISO.
    - If the state was START, CFG, NULL, MSB or LSB, pulse frame_abort for 1 clk.
    - From HOLD, or from MSB after conv_done has fired, there is no abort pulse.
- Simultaneous events: a CS_n rise takes priority over an SCK edge detected in the same clk.
- SCK edges while cs_n is high are ignored.
- A frame started with cs_n already low at reset release is ignored until cs_n goes high and then low again.
- Arithmetic for the latched sample:
  - SGL=1: sample is ch0_value (ODD=0) or ch1_value (ODD=1).
  - SGL=0, ODD=0: sample is ch0−ch1.
  - SGL=0, ODD=1: sample is ch1−ch0.
  - Differential results use 13-bit signed subtraction and saturate to 0 when negative; the result is then 12 bits.
  - ch inputs change freely; only the value latched at the MSBF edge is transmitted.
- rst asserted mid-frame forces all reset values immediately and produces no pulses.

Optional Feature:
- Macro: ADC_RESPONDER_NOISE_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances once per latch.
  - Its two LSBs add dither to the latched sample: 00→+0, 01→+1, 10→−1, 11→+0.
  - The dithered result saturates to the range 0–4095.
- Undefined: no LFSR is present and the latched sample is exact.

Test Plan:
- SGL=1, ODD=0, MSBF=1, ch0=12'hA5C, 20 SCK clocks at 1/16 clk: MISO bits after start = 0, 1010_0101_1100, then 0s. conv_done pulses once, last_ch=0.
- SGL=1, ODD=1, MSBF=0, ch1=12'h801: MISO = 0, 1000_0000_0001, then LSB-first D1..D11 = 000_0000_0001, then 0. last_ch=1.
- SGL=0, ODD=0 with ch0=100, ch1=300: result 0. With ODD=1: result 200 (12'h0C8).
- Two leading mosi zeros before the start bit: same output as the first scenario, shifted by two SCK periods.
- CS_n raised after 5 data bits: frame_abort is a single pulse, oe drops within SYNC_STAGES+1 clk, no conv_done. The next frame decodes correctly.
- rst pulsed during the MSB phase: all outputs at reset values within 1 clk. SCK edges with cs_n held low afterwards produce no response until a fresh cs_n falling edge.

Source files
------------

// File: rtl/spi_adc_responder.sv
// Behavioural SPI responder for a 2-channel 12-bit MCP3202-class ADC, decoded on oversampled SPI inputs.
// Optional feature: define ADC_RESPONDER_NOISE_EN to dither the latched sample with a 16-bit LFSR.
module spi_adc_responder #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic        IDLE_MISO   = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        spi_sck,
   input  logic        spi_cs_n,
   input  logic        spi_mosi,
   output logic        spi_miso,
   output logic        spi_miso_oe,
   input  logic [11:0] ch0_value,
   input  logic [11:0] ch1_value,
   output logic        conv_done,
   output logic        last_ch,
   output logic        last_sgl,
   output logic        frame_abort
);
   localparam int unsigned DW = 12;

   typedef enum logic [2:0] {S_IDLE, S_START, S_CFG, S_NULL, S_MSB, S_LSB, S_HOLD} state_t;

   state_t                 r_state;
   logic [SYNC_STAGES-1:0] r_sck_sync, r_cs_sync, r_mosi_sync, r_vld;
   logic                   r_sck_prev, r_cs_prev, r_armed;
   logic                   r_sgl, r_odd, r_msbf;
   logic [1:0]             r_cfg_cnt;
   logic [3:0]             r_bit_cnt;
   logic [DW-1:0]          r_sample;
   logic                   w_sck_s, w_cs_s, w_mosi_s;
   logic                   w_sck_rise, w_sck_fall, w_cs_rise, w_cs_fall;
   logic [DW-1:0]          w_sel_a, w_sel_b, w_base, w_sample;
   logic [DW:0]            w_diff;
`ifdef ADC_RESPONDER_NOISE_EN
   logic [15:0]            r_lfsr;
   logic [DW+1:0]          w_dith;
`endif

   // Input synchronisers; r_vld marks when the chain holds only post-reset samples
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sck_sync  <= '0;
         r_cs_sync   <= '1;
         r_mosi_sync <= '0;
         r_vld       <= '0;
         r_sck_prev  <= 1'b0;
         r_cs_prev   <= 1'b1;
      end else begin
         r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], spi_sck};
         r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_n};
         r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
         r_vld       <= {r_vld[SYNC_STAGES-2:0], 1'b1};
         r_sck_prev  <= w_sck_s;
         r_cs_prev   <= w_cs_s;
      end
   end

   assign w_sck_s    = r_sck_sync[SYNC_STAGES-1];
   assign w_cs_s     = r_cs_sync[SYNC_STAGES-1];
   assign w_mosi_s   = r_mosi_sync[SYNC_STAGES-1];
   assign w_sck_rise = w_sck_s & ~r_sck_prev & ~w_cs_s;
   assign w_sck_fall = ~w_sck_s & r_sck_prev & ~w_cs_s;
   assign w_cs_rise  = w_cs_s & ~r_cs_prev;
   assign w_cs_fall  = ~w_cs_s & r_cs_prev;

   // Sample selection; differential results clamp negative values to zero
   always_comb begin
      w_sel_a = r_odd ? ch1_value : ch0_value;
      w_sel_b = r_odd ? ch0_value : ch1_value;
      w_diff  = {1'b0, w_sel_a} - {1'b0, w_sel_b};
      if (r_sgl)          w_base = w_sel_a;
      else if (w_diff[DW]) w_base = '0;
      else                w_base = w_diff[DW-1:0];
`ifdef ADC_RESPONDER_NOISE_EN
      case (r_lfsr[1:0])
         2'b01:   w_dith = {2'b00, w_base} + (DW+2)'(1);
         2'b10:   w_dith = {2'b00, w_base} - (DW+2)'(1);
         default: w_dith = {2'b00, w_base};
      endcase
      if (w_dith[DW+1])   w_sample = '0;
      else if (w_dith[DW]) w_sample = '1;
      else                w_sample = w_dith[DW-1:0];
`else
      w_sample = w_base;
`endif
   end

   // Frame state machine with registered MISO/status outputs; CS_n rise wins over SCK edges
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         spi_miso    <= IDLE_MISO;
         spi_miso_oe <= 1'b0;
         conv_done   <= 1'b0;
         frame_abort <= 1'b0;
         last_ch     <= 1'b0;
         last_sgl    <= 1'b0;
         r_armed     <= 1'b0;
         r_sgl       <= 1'b0;
         r_odd       <= 1'b0;
         r_msbf      <= 1'b0;
         r_cfg_cnt   <= '0;
         r_bit_cnt   <= '0;
         r_sample    <= '0;
`ifdef ADC_RESPONDER_NOISE_EN
         r_lfsr      <= 16'hACE1;
`endif
      end else begin
         conv_done   <= 1'b0;
         frame_abort <= 1'b0;
         if (r_vld[SYNC_STAGES-1] && w_cs_s) r_armed <= 1'b1;
         if (r_state != S_IDLE && w_cs_rise) begin
            r_state     <= S_IDLE;
            spi_miso_oe <= 1'b0;
            spi_miso    <= IDLE_MISO;
            frame_abort <= (r_state != S_HOLD);
         end else begin
            case (r_state)
               S_IDLE: begin
                  spi_miso_oe <= 1'b0;
                  spi_miso    <= IDLE_MISO;
                  if (w_cs_fall && r_armed) r_state <= S_START;
               end
               S_START: if (w_sck_rise && w_mosi_s) begin
                  r_state   <= S_CFG;
                  r_cfg_cnt <= '0;
               end
               S_CFG: if (w_sck_rise) begin
                  case (r_cfg_cnt)
                     2'd0: begin r_sgl <= w_mosi_s; r_cfg_cnt <= 2'd1; end
                     2'd1: begin r_odd <= w_mosi_s; r_cfg_cnt <= 2'd2; end
                     default: begin
                        r_msbf   <= w_mosi_s;
                        r_sample <= w_sample;
                        r_state  <= S_NULL;
`ifdef ADC_RESPONDER_NOISE_EN
                        r_lfsr   <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
`endif
                     end
                  endcase
               end
               S_NULL: if (w_sck_fall) begin
                  spi_miso    <= 1'b0;
                  spi_miso_oe <= 1'b1;
                  r_bit_cnt   <= 4'd11;
                  r_state     <= S_MSB;
               end
               S_MSB: if (w_sck_fall) begin
                  spi_miso <= r_sample[r_bit_cnt];
                  if (r_bit_cnt == 4'd0) begin
                     conv_done <= 1'b1;
                     last_ch   <= r_odd;
                     last_sgl  <= r_sgl;
                     r_bit_cnt <= 4'd1;
                     r_state   <= r_msbf ? S_HOLD : S_LSB;
                  end else begin
                     r_bit_cnt <= r_bit_cnt - 4'd1;
                  end
               end
               S_LSB: if (w_sck_fall) begin
                  spi_miso <= r_sample[r_bit_cnt];
                  if (r_bit_cnt == 4'd11) r_state <= S_HOLD;
                  else                    r_bit_cnt <= r_bit_cnt + 4'd1;
               end
               S_HOLD: if (w_sck_fall) spi_miso <= 1'b0;
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end
endmodule
